// File: rtl/q610_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | q610_pkg: shared Q6.10 types, constants and leading-zero count helper |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package q610_pkg;

  localparam int          Q_W            = 16;
  localparam int          Q_FRAC         = 10;
  localparam int          LOG_INT_OFFSET = 5;
  localparam logic [15:0] QUOT_SAT       = 16'hFFFF;

  typedef logic [Q_W-1:0] q610_t;

  // Higher set bits override lower ones, so the MSB wins; zero input yields 15.
  function automatic logic [3:0] lzc16(input logic [15:0] v);
    lzc16 = 4'd15;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) lzc16 = 4'(15 - i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pow2_mitchell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pow2_mitchell: Mitchell 2^(n + f/1024) in unsigned Q6.10, saturating |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pow2_mitchell
  import q610_pkg::*;
(
  input  logic signed [6:0] n,
  input  logic        [9:0] f,
  output q610_t             quot,
  output logic              sat
);

  logic [10:0] w_mant;

  always_comb begin
    w_mant = {1'b1, f};
    quot   = '0;
    sat    = 1'b0;
    if (n >= 7'sd6) begin
      quot = QUOT_SAT;
      sat  = 1'b1;
    end else if (n >= 7'sd0) begin
      quot = q610_t'(w_mant) << n[2:0];
    end else if (n <= -7'sd11) begin
      quot = '0;
    end else begin
      // Right shift by 1..10, truncating.
      quot = q610_t'(w_mant) >> (-n);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stage2_log_div_pow2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stage2_log_div_pow2: 4-stage log-domain divide, quot ~ in_1 / in_0    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module stage2_log_div_pow2
  import q610_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        valid_in,
  input  logic [15:0] log_in_0,
  input  logic [15:0] in_0_bypass,
  input  logic [15:0] in_1_bypass,
  output logic        valid_out,
  output logic [15:0] quot_out,
  output logic        sat_out,
  output logic        dz_out
);

  if (DATA_W != Q_W || FRAC_W != Q_FRAC) begin : g_param_check
    $error("stage2_log_div_pow2: datapath is fixed at Q6.10");
  end

  // S0
  logic  r0_valid;
  q610_t r0_log0, r0_in0, r0_in1;
  // S1
  logic  r1_valid, r1_z0, r1_z1;
  q610_t r1_log0, r1_log1;
  // S2
  logic              r2_valid, r2_z0, r2_z1;
  logic signed [6:0] r2_n;
  logic        [9:0] r2_f;

  logic [3:0]  w_lzc1;
  logic [9:0]  w_frac1;
  q610_t       w_log1;
  logic [16:0] w_diff;
  q610_t       w_quot;
  logic        w_sat;

  assign w_lzc1  = lzc16(r0_in1);
  assign w_frac1 = 10'((r0_in1 << w_lzc1) >> 5);
  assign w_log1  = {6'(LOG_INT_OFFSET - int'(w_lzc1)), w_frac1};
  assign w_diff  = {r1_log1[15], r1_log1} - {r1_log0[15], r1_log0};

  pow2_mitchell u_pow2 (
    .n    (r2_n),
    .f    (r2_f),
    .quot (w_quot),
    .sat  (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid  <= 1'b0;
      r0_log0   <= '0;
      r0_in0    <= '0;
      r0_in1    <= '0;
      r1_valid  <= 1'b0;
      r1_z0     <= 1'b0;
      r1_z1     <= 1'b0;
      r1_log0   <= '0;
      r1_log1   <= '0;
      r2_valid  <= 1'b0;
      r2_z0     <= 1'b0;
      r2_z1     <= 1'b0;
      r2_n      <= '0;
      r2_f      <= '0;
      valid_out <= 1'b0;
      quot_out  <= '0;
      sat_out   <= 1'b0;
      dz_out    <= 1'b0;
    end else if (en) begin
      r0_valid <= valid_in;
      r0_log0  <= log_in_0;
      r0_in0   <= in_0_bypass;
      r0_in1   <= in_1_bypass;

      r1_valid <= r0_valid;
      r1_z0    <= (r0_in0 == '0);
      r1_z1    <= (r0_in1 == '0);
      r1_log0  <= r0_log0;
      r1_log1  <= w_log1;

      r2_valid <= r1_valid;
      r2_z0    <= r1_z0;
      r2_z1    <= r1_z1;
      r2_n     <= w_diff[16:10];
      r2_f     <= w_diff[9:0];

      // Divide-by-zero overrides everything, since log_in_0 is garbage then.
      valid_out <= r2_valid;
      if (!r2_valid) begin
        quot_out <= '0;
        sat_out  <= 1'b0;
        dz_out   <= 1'b0;
      end else if (r2_z0) begin
        quot_out <= QUOT_SAT;
        sat_out  <= 1'b1;
        dz_out   <= 1'b1;
      end else if (r2_z1) begin
        quot_out <= '0;
        sat_out  <= 1'b0;
        dz_out   <= 1'b0;
      end else begin
        quot_out <= w_quot;
        sat_out  <= w_sat;
        dz_out   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/stage2_log_div_pow2.md
Name: stage2_log_div_pow2

Overview:
Downstream neighbour of the stage-1 log2 approximator in the Q6.10 baseline datapath. Consumes log2(in_0) and the bypassed raw operands. Computes log2(in_1) with the same leading-one/Mitchell scheme, subtracts, and applies a Mitchell pow2 approximation to produce quot ≈ in_1 / in_0 in unsigned Q6.10. The pipeline has 4 register stages, advanced by a global enable, with valid tagging and saturation/div-by-zero flags.

Parameters:
DATA_W, 16, operand and result width; the datapath is fixed at 16, and this parameter is for documentation and asserts only.
FRAC_W, 10, fractional bits of the Q6.10 format; fixed at 10.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  pipeline enable; all stage registers hold when low
valid_in  in  1  stage-1 valid_out
log_in_0  in  16  stage-1 log2(in_0): signed Q6.10, int = 5 - lzc(in_0), frac = (in_0 << lzc)[14:5]
in_0_bypass  in  16  raw divisor, unsigned Q6.10
in_1_bypass  in  16  raw dividend, unsigned Q6.10
valid_out  out  1  result valid
quot_out  out  16  unsigned Q6.10 quotient approximation
sat_out  out  1  result clamped to 0xFFFF
dz_out  out  1  in_0_bypass was zero

Behaviour:
- Reset: all stage registers clear to 0, so valid_out=0, quot_out=0x0000, sat_out=0, dz_out=0. Reset has priority over en.
- en=0: every register holds, and outputs stay stable. en=1: every stage advances by one. There is no backpressure beyond en.
- Latency is exactly 4 enabled cycles from valid_in to valid_out. Throughput is 1 per enabled cycle. Bubbles (valid_in=0) propagate and are never squeezed.
- S0 registers {valid_in, log_in_0, in_0_bypass, in_1_bypass}.
- S1 computes lzc1 (0..15) as the leading-zero count of in_1, using a full 16-bit priority encoder with a defined default.
  - z1 = (in_1==0) and z0 = (in_0==0).
  - log1 = {6'(5 - lzc1), (in_1 << lzc1)[14:5]}.
  - S1 registers log1, z0, z1, and log_in_0.
  - The stage-1 log value is never trusted when in_0==0.
- S2 computes the 17-bit signed diff = sext(log1) - sext(log_in_0), with range [-16, +16).
  - n = diff[16:10] (7-bit signed) and f = diff[9:0]. Registers n, f, z0, z1.
- S3 computes mant = {1'b1, f} (11 bits).
  - If z0: quot=0xFFFF, sat=1, dz=1.
  - Else if z1: quot=0x0000, sat=0.
  - Else if n >= 6: quot=0xFFFF, sat=1.
  - Else if n >= 0: quot = mant << n (max 2047<<5 = 0xFFE0, no overflow).
  - Else if n <= -11: quot=0x0000.
  - Else: quot = mant >> -n, truncated with no rounding.
- Flags are registered with quot, are meaningful only when valid_out=1, and are forced to 0 for bubbles.
- Rst asserted mid-stream flushes all in-flight items, which are lost, and the pipeline restarts empty.

Decomposition:
- Shared package q610_pkg:
  - localparams Q_W=16, Q_FRAC=10, LOG_INT_OFFSET=5, QUOT_SAT=16'hFFFF.
  - typedef q610_t (logic [15:0]).
  - function lzc16 (16-bit leading-zero count, returning 0..15 with default 15).
- One sub-module, pow2_mitchell (n, f -> quot, sat), is the S3 combinational logic and is reusable by later exp/softmax stages.
- The lzc function is shared with stage 1 rework.

Test Plan:
- in_0=0x0400, log_in_0=0x0000, in_1=0x0C00, en=1 -> after 4 cycles valid_out=1, quot_out=0x0C00, sat=0, dz=0.
- in_0=0x0800, log_in_0=0x0400, in_1=0x0400 -> quot_out=0x0200. Divisor 0x0001 (log_in_0=0xD800) with in_1=0x8000 -> n=15, quot_out=0xFFFF, sat=1.
- in_0=0x0000 with any log_in_0 and in_1=0x1234 -> quot_out=0xFFFF, sat=1, dz=1. in_0=0x0400, in_1=0x0000 -> quot_out=0x0000, sat=0.
- in_1=0x0001, in_0=0x8000, log_in_0=0x1400 -> n=-15 -> quot_out=0x0000. Check the truncation case n=-1, f=0x3FF -> 0x03FF.
- Back-to-back valids, then en=0 for 3 cycles mid-stream -> outputs frozen, no duplicates or drops, order preserved. Alternating valid_in pattern yields the identical valid_out pattern 4 enabled cycles later.
- Assert rst with 3 items in flight -> next cycle valid_out=0, quot_out=0, flags 0, and no stale items emerge afterwards.
